// File: rtl/mk14_pkg.sv
// mk14_pkg: shared constants and types for the Mk14 display RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mk14_pkg;

   // First bus address mapped onto display RAM word 0.
   localparam logic [15:0] MK14_BASE_ADDR = 16'h0200;

   // Arbiter states: S_IDLE arbitrates; S_CPU is the CPU ack cycle.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_CPU  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ram_sync.sv
// ram_sync: single-port synchronous RAM, write-enable plus registered read.
// Latency: read data appears 1 cycle after the address; writes land at the clock edge.
// Backpressure: none, accepts one access every cycle.
// Ports: i_clk clock; i_we write enable; i_addr word index; i_wdata write data; o_rdata registered read data.
module ram_sync #(
   parameter int    WIDTH  = 8,
   parameter int    DEPTH  = 512,
   parameter string INIT_F = ""
) (
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_addr,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata
);

   // Preloading from INIT_F is left to the memory-init step of the FPGA
   // flow; the parameter is carried so instances stay interchangeable.
   localparam string unused_init_f = INIT_F;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Read-first: a write returns the old word on o_rdata. The arbiter never
   // uses the read result of a write cycle, so no bypass is needed.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_addr] <= i_wdata;
      end
      rdata_q <= mem_q[i_addr];
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/vdu_mem_arbiter.sv
// vdu_mem_arbiter: shares the single-port display RAM between the VDU fetch port and the CPU bus.
// Latency: VDU data valid 1 cycle after read_en; CPU ack 1 cycle after grant (2 clocks min per access).
// Backpressure: VDU always wins; a pending CPU request is stalled (o_cpu_stall) while read_en is high.
// Ports: i_clk/i_rst clock and sync reset; i_vdu_read_en/i_vdu_read_addr/o_vdu_data VDU fetch port;
//        i_cpu_req/i_cpu_we/i_cpu_addr/i_cpu_wdata CPU request; o_cpu_ack/o_cpu_rdata/o_cpu_stall CPU response.
module vdu_mem_arbiter
   import mk14_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = MK14_BASE_ADDR,
   parameter int          DEPTH     = 512,
   parameter string       INIT_F    = ""
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_vdu_read_en,
   input  logic [15:0] i_vdu_read_addr,
   output logic [7:0]  o_vdu_data,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [15:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_wdata,
   output logic        o_cpu_ack,
   output logic [7:0]  o_cpu_rdata,
   output logic        o_cpu_stall
);

   localparam int AW = $clog2(DEPTH);

   arb_state_t    state_q, state_d;
   logic          cpu_we_q, cpu_we_d;
   logic [7:0]    cpu_rdata_q;
   logic          vdu_en_q;
   logic [7:0]    vdu_data_q;

   logic          cpu_grant;
   logic [AW-1:0] vdu_idx, cpu_idx, ram_addr;
   logic          ram_we;
   logic [7:0]    ram_rdata;

   // Requests are guaranteed to be in window; the offset is simply truncated.
   assign vdu_idx = AW'(i_vdu_read_addr - BASE_ADDR);
   assign cpu_idx = AW'(i_cpu_addr - BASE_ADDR);

   always_comb begin
      state_d     = state_q;
      cpu_we_d    = cpu_we_q;
      cpu_grant   = 1'b0;
      o_cpu_ack   = 1'b0;
      o_cpu_stall = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_vdu_read_en) begin
               o_cpu_stall = i_cpu_req;
            end else if (i_cpu_req) begin
               cpu_grant = 1'b1;
               cpu_we_d  = i_cpu_we;
               state_d   = S_CPU;
            end
         end
         S_CPU: begin
            // Unconditional return: a request still high here is ignored.
            o_cpu_ack = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The VDU owns the address whenever read_en is high, even in the ack
   // cycle; the CPU's read word is already sitting in the RAM output register.
   assign ram_addr = i_vdu_read_en ? vdu_idx : cpu_idx;
   assign ram_we   = cpu_grant & i_cpu_we;

   ram_sync #(
      .WIDTH  (8),
      .DEPTH  (DEPTH),
      .INIT_F (INIT_F)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_addr  (ram_addr),
      .i_wdata (i_cpu_wdata),
      .o_rdata (ram_rdata)
   );

   // Both outputs pass the RAM word straight through in its valid cycle and
   // otherwise show the held copy, so the value is usable in the ack cycle.
   assign o_cpu_rdata = (o_cpu_ack && !cpu_we_q) ? ram_rdata : cpu_rdata_q;
   assign o_vdu_data  = vdu_en_q ? ram_rdata : vdu_data_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         cpu_we_q    <= 1'b0;
         cpu_rdata_q <= 8'h00;
         vdu_en_q    <= 1'b0;
         vdu_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cpu_we_q    <= cpu_we_d;
         cpu_rdata_q <= o_cpu_rdata;
         vdu_en_q    <= i_vdu_read_en;
         vdu_data_q  <= o_vdu_data;
      end
   end

endmodule

// File: tb/tb_vdu_mem_arbiter.sv
module tb_vdu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        vdu_en;
   logic [15:0] vdu_addr;
   logic [7:0]  vdu_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_stall;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_mem [512];

   always #5 clk = ~clk;

   vdu_mem_arbiter #(
      .BASE_ADDR (16'h0200),
      .DEPTH     (512),
      .INIT_F    ("")
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_vdu_read_en   (vdu_en),
      .i_vdu_read_addr (vdu_addr),
      .o_vdu_data      (vdu_data),
      .i_cpu_req       (cpu_req),
      .i_cpu_we        (cpu_we),
      .i_cpu_addr      (cpu_addr),
      .i_cpu_wdata     (cpu_wdata),
      .o_cpu_ack       (cpu_ack),
      .o_cpu_rdata     (cpu_rdata),
      .o_cpu_stall     (cpu_stall)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx(input logic [15:0] a);
      return int'(a - 16'h0200) & 511;
   endfunction

   function automatic logic [7:0] burst_val(input int i);
      return 8'(8'h30 + i * 5);
   endfunction

   function automatic logic [15:0] rnd_addr();
      logic [5:0] r;
      r = 6'($urandom);
      return 16'h0200 + (r[5] ? 16'h01E0 : 16'h0000) + {11'd0, r[4:0]};
   endfunction

   // Plain write with the VDU idle: grant cycle, ack cycle, one idle cycle.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      next_cycle();
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0;
      model_mem[idx(a)] = d;
      next_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1; vdu_en = 1'b0; vdu_addr = 16'h0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = 16'h0; cpu_wdata = 8'h0;
      @(posedge clk); @(posedge clk); #1;
      #3;
      checks++; if (cpu_ack !== 1'b0)    begin errors++; $display("FAIL reset_ack got %b want 0", cpu_ack); end
      checks++; if (cpu_stall !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", cpu_rdata); end
      checks++; if (vdu_data !== 8'h00)  begin errors++; $display("FAIL reset_vdu got %h want 00", vdu_data); end
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_cpu_write_read();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0210; cpu_wdata = 8'h5A;
      #3;
      checks++; if (cpu_ack !== 1'b0)   begin errors++; $display("FAIL wr_grant_ack got %b want 0", cpu_ack); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr_stall got %b want 0", cpu_stall); end
      next_cycle(); #3;
      checks++; if (cpu_ack !== 1'b1)   begin errors++; $display("FAIL wr_ack got %b want 1", cpu_ack); end
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0; model_mem[idx(16'h0210)] = 8'h5A;
      #3;
      checks++; if (cpu_ack !== 1'b0)   begin errors++; $display("FAIL wr_after_ack got %b want 0", cpu_ack); end
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0210;
      next_cycle(); #3;
      checks++; if (cpu_ack !== 1'b1)    begin errors++; $display("FAIL rd_ack got %b want 1", cpu_ack); end
      checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data got %h want 5a", cpu_rdata); end
      next_cycle();
      cpu_req = 1'b0;
      #3;
      checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL rd_hold got %h want 5a", cpu_rdata); end
      checks++; if (cpu_ack !== 1'b0)    begin errors++; $display("FAIL rd_ack_drop got %b want 0", cpu_ack); end
      next_cycle();
   endtask

   task automatic test_vdu_read();
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h00; exp_seq[1] = 8'h5A; exp_seq[2] = 8'h5A; exp_seq[3] = 8'h5A;
      for (int k = 0; k < 4; k++) begin
         vdu_en = (k < 2); vdu_addr = 16'h0210;
         #3;
         checks++;
         if (vdu_data !== exp_seq[k]) begin
            errors++; $display("FAIL vdu_read cyc %0d got %h want %h", k, vdu_data, exp_seq[k]);
         end
         next_cycle();
      end
   endtask

   task automatic test_stall_burst();
      int stall_cycles = 0;
      logic [7:0] exp_v;
      for (int i = 0; i < 34; i++) cpu_write(16'h0220 + 16'(i), burst_val(i));
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0220;
      for (int i = 0; i < 34; i++) begin
         vdu_en = 1'b1; vdu_addr = 16'h0220 + 16'(i);
         exp_v = (i == 0) ? 8'h5A : burst_val(i - 1);
         #3;
         if (cpu_stall === 1'b1) stall_cycles++;
         checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL burst_ack cyc %0d got %b want 0", i, cpu_ack); end
         checks++; if (vdu_data !== exp_v) begin errors++; $display("FAIL burst_vdu cyc %0d got %h want %h", i, vdu_data, exp_v); end
         next_cycle();
      end
      checks++; if (stall_cycles != 34) begin errors++; $display("FAIL burst_stall_cycles got %0d want 34", stall_cycles); end
      vdu_en = 1'b0;
      #3;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL burst_stall_end got %b want 0", cpu_stall); end
      checks++; if (cpu_ack !== 1'b0)   begin errors++; $display("FAIL burst_grant_ack got %b want 0", cpu_ack); end
      checks++; if (vdu_data !== burst_val(33)) begin errors++; $display("FAIL burst_vdu_last got %h want %h", vdu_data, burst_val(33)); end
      next_cycle(); #3;
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL burst_ack_late got %b want 1", cpu_ack); end
      checks++; if (cpu_rdata !== burst_val(0)) begin errors++; $display("FAIL burst_rdata got %h want %h", cpu_rdata, burst_val(0)); end
      checks++; if (vdu_data !== burst_val(33)) begin errors++; $display("FAIL burst_vdu_hold got %h want %h", vdu_data, burst_val(33)); end
      next_cycle();
      cpu_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0221;
      #3;
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_grant1 got %b want 0", cpu_ack); end
      next_cycle(); #3;
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b want 1", cpu_ack); end
      checks++; if (cpu_rdata !== burst_val(1)) begin errors++; $display("FAIL b2b_data1 got %h want %h", cpu_rdata, burst_val(1)); end
      next_cycle();
      cpu_addr = 16'h0222;
      #3;
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", cpu_ack); end
      checks++; if (cpu_rdata !== burst_val(1)) begin errors++; $display("FAIL b2b_hold got %h want %h", cpu_rdata, burst_val(1)); end
      next_cycle(); #3;
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b want 1", cpu_ack); end
      checks++; if (cpu_rdata !== burst_val(2)) begin errors++; $display("FAIL b2b_data2 got %h want %h", cpu_rdata, burst_val(2)); end
      next_cycle();
      cpu_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_vdu_during_cpu();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0223;
      next_cycle();
      vdu_en = 1'b1; vdu_addr = 16'h0224;
      #3;
      checks++; if (cpu_ack !== 1'b1)   begin errors++; $display("FAIL vcpu_ack got %b want 1", cpu_ack); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL vcpu_stall got %b want 0", cpu_stall); end
      checks++; if (cpu_rdata !== burst_val(3)) begin errors++; $display("FAIL vcpu_rdata got %h want %h", cpu_rdata, burst_val(3)); end
      next_cycle();
      vdu_en = 1'b0; cpu_req = 1'b0;
      #3;
      checks++; if (vdu_data !== burst_val(4)) begin errors++; $display("FAIL vcpu_vdu got %h want %h", vdu_data, burst_val(4)); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL vcpu_ack_drop got %b want 0", cpu_ack); end
      next_cycle();
   endtask

   task automatic test_reset_mid_cpu();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0230; cpu_wdata = 8'hC3;
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      model_mem[idx(16'h0230)] = 8'hC3;
      #3;
      checks++; if (cpu_ack !== 1'b0)    begin errors++; $display("FAIL rstmid_ack got %b want 0", cpu_ack); end
      checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rdata got %h want 00", cpu_rdata); end
      checks++; if (vdu_data !== 8'h00)  begin errors++; $display("FAIL rstmid_vdu got %h want 00", vdu_data); end
      next_cycle();
      vdu_en = 1'b1; vdu_addr = 16'h0230;
      next_cycle();
      vdu_en = 1'b0;
      #3;
      checks++; if (vdu_data !== 8'hC3) begin errors++; $display("FAIL rstmid_write_kept got %h want c3", vdu_data); end
      next_cycle();
   endtask

   // Random VDU bursts against a transaction-level CPU model: a request made
   // in cycle s is granted in the first cycle g >= s without VDU read_en and
   // acked in g+1; it stalls in every cycle of [s, g).
   task automatic test_random();
      localparam int N = 1200;
      bit          ven [N];
      logic [15:0] va  [N];
      int c, g, ack_c;
      bit pend;
      logic t_we; logic [15:0] t_addr; logic [7:0] t_wd;
      logic [7:0] rd_val, held, exp_vdu;
      logic exp_ack, exp_stall;

      rst = 1'b1; vdu_en = 1'b0; cpu_req = 1'b0;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      for (int r = 0; r < 64; r++) begin
         logic [15:0] a;
         a = 16'h0200 + (r[5] ? 16'h01E0 : 16'h0000) + 16'(r[4:0]);
         cpu_write(a, 8'($urandom));
      end

      c = 0;
      while (c < N - 40) begin
         int gap, len;
         gap = $urandom_range(0, 6);
         len = $urandom_range(1, 35);
         for (int k = 0; k < gap && c < N - 40; k++) begin ven[c] = 1'b0; va[c] = rnd_addr(); c++; end
         for (int k = 0; k < len && c < N - 40; k++) begin ven[c] = 1'b1; va[c] = rnd_addr(); c++; end
      end
      for (; c < N; c++) begin ven[c] = 1'b0; va[c] = rnd_addr(); end

      pend = 1'b0; g = -1; ack_c = -1; t_we = 1'b0; t_addr = 16'h0200; t_wd = 8'h00;
      rd_val = 8'h00; held = 8'h00; exp_vdu = 8'h00;
      for (int cy = 0; cy < N; cy++) begin
         if (!pend && cy < N - 40 && $urandom_range(0, 2) != 0) begin
            pend = 1'b1;
            t_we = 1'($urandom_range(0, 1)); t_addr = rnd_addr(); t_wd = 8'($urandom);
            g = cy;
            while (ven[g]) g++;
            ack_c = g + 1;
         end
         vdu_en = ven[cy]; vdu_addr = va[cy];
         cpu_req = pend; cpu_we = t_we; cpu_addr = t_addr; cpu_wdata = t_wd;
         if (cy > 0 && ven[cy - 1]) exp_vdu = model_mem[idx(va[cy - 1])];
         exp_ack   = pend && (cy == ack_c);
         exp_stall = pend && (cy < g);
         if (exp_ack && !t_we) held = rd_val;
         #3;
         checks++; if (cpu_ack !== exp_ack)     begin errors++; $display("FAIL rnd_ack cyc %0d got %b want %b", cy, cpu_ack, exp_ack); end
         checks++; if (cpu_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", cy, cpu_stall, exp_stall); end
         checks++; if (cpu_rdata !== held)      begin errors++; $display("FAIL rnd_rdata cyc %0d got %h want %h", cy, cpu_rdata, held); end
         checks++; if (vdu_data !== exp_vdu)    begin errors++; $display("FAIL rnd_vdu cyc %0d got %h want %h", cy, vdu_data, exp_vdu); end
         if (pend && cy == g) begin
            if (t_we) model_mem[idx(t_addr)] = t_wd;
            else      rd_val = model_mem[idx(t_addr)];
         end
         if (exp_ack) pend = 1'b0;
         next_cycle();
      end
      cpu_req = 1'b0; vdu_en = 1'b0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_cpu_write_read();
      test_vdu_read();
      test_stall_burst();
      test_back_to_back();
      test_vdu_during_cpu();
      test_reset_mid_cpu();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
